// File: rtl/barrett_reducer.sv
// Multi-cycle Barrett reducer: r = x mod m for a 2*BITWIDTH-bit x.
// One (BITWIDTH+1)x(BITWIDTH+1) multiplier is time-shared between the two quotient steps.
module barrett_reducer #(
  parameter int unsigned BITWIDTH = 32
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*BITWIDTH-1:0]   x,
  input  logic [BITWIDTH-1:0]     m,
  input  logic [BITWIDTH:0]       mu,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BITWIDTH-1:0]     r,
  output logic                    err
);

  localparam int unsigned BW = BITWIDTH;
  localparam int unsigned XW = 2 * BW;
  localparam int unsigned OW = BW + 1;
  localparam int unsigned PW = 2 * BW + 2;
  localparam int unsigned TW = BW + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL1,
    S_MUL2,
    S_SUB,
    S_COR1,
    S_COR2,
    S_DONE
  } state_t;

  state_t state_q, state_n;

  logic [XW-1:0] x_q;
  logic [BW-1:0] m_q;
  logic [OW-1:0] mu_q;
  logic [PW-1:0] p_q;
  logic [TW-1:0] t_q;

  logic [OW-1:0] mul_a, mul_b;
  logic [PW-1:0] prod;
  logic [TW-1:0] m_ext, t_cor;
  logic          legal_c;

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= S_IDLE;
    else            state_q <= state_n;
  end

  // Next-state logic: one state per cycle, fixed latency
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid) state_n = S_MUL1;
      S_MUL1:  state_n = S_MUL2;
      S_MUL2:  state_n = S_SUB;
      S_SUB:   state_n = S_COR1;
      S_COR1:  state_n = S_COR2;
      S_COR2:  state_n = S_DONE;
      S_DONE:  if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Shared multiplier: q1*mu in MUL1, q3*{0,m} otherwise
  always_comb begin
    if (state_q == S_MUL1) begin
      mul_a = x_q[XW-1:BW-1];
      mul_b = mu_q;
    end else begin
      mul_a = p_q[PW-1:BW+1];
      mul_b = {1'b0, m_q};
    end
    prod = PW'(mul_a) * PW'(mul_b);
  end

  // Conditional subtraction used by both correction steps
  always_comb begin
    m_ext = TW'(m_q);
    t_cor = (t_q >= m_ext) ? (t_q - m_ext) : t_q;
  end

  // Modulus must have its top bit set and not be exactly 2^(BW-1)
  assign legal_c = m[BW-1] && (m[BW-2:0] != '0);

  // Datapath and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_q       <= '0;
      m_q       <= '0;
      mu_q      <= '0;
      p_q       <= '0;
      t_q       <= '0;
      r         <= '0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_n == S_IDLE);
      out_valid <= (state_n == S_DONE);
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            x_q  <= x;
            m_q  <= m;
            mu_q <= mu;
            err  <= !legal_c;
          end
        end
        S_MUL1, S_MUL2: p_q <= prod;
        S_SUB:          t_q <= x_q[TW-1:0] - p_q[TW-1:0];
        S_COR1:         t_q <= t_cor;
        S_COR2: begin
          t_q <= t_cor;
          r   <= err ? '0 : t_cor[BW-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_barrett_reducer.sv
// Directed bench for barrett_reducer at BITWIDTH=8, plus a short random sweep
// against x % m with mu computed locally.
module tb_barrett_reducer;

  localparam int unsigned BW = 8;

  logic            sys_clk = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2*BW-1:0] x = '0;
  logic [BW-1:0]   m = '0;
  logic [BW:0]     mu = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [BW-1:0]   r;
  logic            err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int prev_acc = 0;
  int lat = 0;

  barrett_reducer #(.BITWIDTH(BW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .m         (m),
    .mu        (mu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .err       (err)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge; the posedge in between is the accept edge.
  task automatic start(input logic [2*BW-1:0] xv, input logic [BW-1:0] mv, input logic [BW:0] muv);
    x = xv; m = mv; mu = muv; in_valid = 1'b1;
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge sys_clk);
    acc_cyc = cyc;
    @(negedge sys_clk);
    in_valid = 1'b0;
    x = '0; m = '0; mu = '0;
  endtask

  // Edges after the accept edge until out_valid is seen, bounded.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge sys_clk);
      n++;
      @(negedge sys_clk);
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("out_valid_after_take", 32'(out_valid), 32'd0);
    check("in_ready_after_take", 32'(in_ready), 32'd1);
  endtask

  // Accept edge plus five more: out_valid rises on the sixth edge counting the accept.
  task automatic run_op(input string tag, input logic [2*BW-1:0] xv, input logic [BW-1:0] mv,
                        input logic [BW:0] muv, input logic [BW-1:0] er, input logic ee);
    int n;
    start(xv, mv, muv);
    wait_out(n);
    check({tag, "_lat"}, 32'(n + 1), 32'd6);
    check({tag, "_r"}, 32'(r), 32'(er));
    check({tag, "_err"}, 32'(err), 32'(ee));
    take();
  endtask

  initial begin
    logic [BW-1:0] hold_r;
    logic [2*BW-1:0] rx;
    logic [BW-1:0] rm;
    logic [BW:0] rmu;
    int n;

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // 1: basic
    run_op("t1", 16'd65535, 8'd251, 9'd261, 8'd24, 1'b0);

    // 2: back-to-back with out_ready high, accepts 7 edges apart
    run_op("t2a", 16'd63001, 8'd251, 9'd261, 8'd0, 1'b0);
    prev_acc = acc_cyc;
    run_op("t2b", 16'd250, 8'd251, 9'd261, 8'd250, 1'b0);
    check("t2_accept_spacing", 32'(acc_cyc - prev_acc), 32'd7);

    // 3: correction steps with the smallest legal modulus family
    run_op("t3a", 16'd1000, 8'd129, 9'd508, 8'd97, 1'b0);
    run_op("t3b", 16'd65535, 8'd129, 9'd508, 8'd3, 1'b0);

    // 4: illegal moduli, then err clears on the next accept
    run_op("t4a", 16'd1234, 8'h80, 9'd261, 8'd0, 1'b1);
    run_op("t4b", 16'd1234, 8'h40, 9'd261, 8'd0, 1'b1);
    run_op("t4c", 16'd65535, 8'd251, 9'd261, 8'd24, 1'b0);

    // 5: back-pressure in DONE while in_valid toggles
    out_ready = 1'b0;
    start(16'd1000, 8'd129, 9'd508);
    wait_out(n);
    hold_r = r;
    check("t5_first_r", 32'(hold_r), 32'd97);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      x = 16'd65535; m = 8'd251; mu = 9'd261;
      @(posedge sys_clk);
      @(negedge sys_clk);
      check("t5_hold_valid", 32'(out_valid), 32'd1);
      check("t5_hold_r", 32'(r), 32'd97);
      check("t5_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    take();
    run_op("t5_next", 16'd65535, 8'd251, 9'd261, 8'd24, 1'b0);

    // 6: asynchronous reset during SUB aborts the run
    start(16'd65535, 8'd251, 9'd261);
    @(posedge sys_clk); @(negedge sys_clk);
    @(posedge sys_clk); @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      check("t6_no_output", 32'(out_valid), 32'd0);
    end
    run_op("t6_next", 16'd63001, 8'd251, 9'd261, 8'd0, 1'b0);

    // Random legal moduli against x % m
    for (int i = 0; i < 300; i++) begin
      rm  = BW'($urandom_range(129, 255));
      rx  = (2*BW)'($urandom_range(0, 65535));
      rmu = (BW+1)'(32'd65536 / 32'(rm));
      run_op("rand", rx, rm, rmu, BW'(32'(rx) % 32'(rm)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
